// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package cla_nibble_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// 4-bit carry-lookahead adder: all internal carries come from generate/propagate terms.
module carry_lookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Wide add/subtract built by stepping one 4-bit CLA across the operands, LS nibble first.
module cla_nibble_sequencer
  import cla_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int N    = num_nibbles(WIDTH);
  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t                  state_r, state_s;
  logic [IDXW-1:0]         idx_r;
  logic [WIDTH-1:0]        a_r, b_r;
  logic [WIDTH-NIBBLE_W-1:0] partial_r;
  logic                    c_r, sub_r;

  logic [NIBBLE_W-1:0] a_nib_s, b_nib_s, sum_nib_s;
  logic                cin_s, cout_nib_s;
  logic                accept_s, last_s;

  assign accept_s = start && (state_r != RUN);
  assign last_s   = (state_r == RUN) && (idx_r == LAST_IDX);

  assign a_nib_s = a_r[int'(idx_r)*NIBBLE_W +: NIBBLE_W];
  assign b_nib_s = b_r[int'(idx_r)*NIBBLE_W +: NIBBLE_W];
  // Nibble 0 takes the subtract carry-in straight from the latched opcode.
  assign cin_s   = (idx_r == '0) ? sub_r : c_r;

  carry_lookahead_adder u_cla (
    .a    (a_nib_s),
    .b    (b_nib_s),
    .cin  (cin_s),
    .sum  (sum_nib_s),
    .cout (cout_nib_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? RUN : IDLE;
      RUN:     state_s = (idx_r == LAST_IDX) ? DONE : RUN;
      DONE:    state_s = start ? RUN : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, operand/carry/index registers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      partial_r <= '0;
      c_r       <= 1'b0;
      sub_r     <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        a_r   <= a;
        b_r   <= op_sub ? ~b : b;
        c_r   <= op_sub;
        sub_r <= op_sub;
        idx_r <= '0;
      end else if (state_r == RUN) begin
        c_r   <= cout_nib_s;
        idx_r <= idx_r + IDXW'(1);
        if (last_s) begin
          result   <= {sum_nib_s, partial_r};
          cout     <= cout_nib_s;
          overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nib_s[NIBBLE_W-1] != a_r[WIDTH-1]);
        end else begin
          partial_r[int'(idx_r)*NIBBLE_W +: NIBBLE_W] <= sum_nib_s;
        end
      end
    end
  end

  assign busy = (state_r == RUN);
  assign done = (state_r == DONE);

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle wide add/subtract unit. It time-multiplexes one 4-bit `carry_lookahead_adder` across the nibbles of a WIDTH-bit operand pair, least-significant nibble first, and carries the ripple between cycles in a register. It sits between the combinational ALU datapath and any requester that needs wide arithmetic without paying for a full-width adder, using a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 8.

Ports:
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled only when the FSM is in IDLE or DONE.
- `op_sub`  in  1: 0 selects a+b; 1 selects a−b. Sampled with `start`.
- `a`  in  WIDTH: operand A. Sampled with `start`.
- `b`  in  WIDTH: operand B. Sampled with `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse; `result`, `cout` and `overflow` are valid from this cycle onward.
- `result`  out  WIDTH: sum or difference, modulo 2^WIDTH.
- `cout`  out  1: carry out of the MSB. For subtract, 1 means no borrow.
- `overflow`  out  1: two's-complement signed overflow.

## Operation
- N = WIDTH/4 nibbles.
- FSM states are IDLE, RUN and DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→RUN while the nibble index is below N−1.
  - RUN→DONE after nibble N−1.
  - DONE→RUN on `start`; otherwise DONE→IDLE.
- Acceptance: on the accepting edge, latch `a_r`=`a` and `b_r`=`op_sub` ? ~`b` : `b`. Set carry register `c_r`=`op_sub`, nibble index `idx`=0, and latch `sub_r`.
- RUN cycle i: the adder inputs are `a_r[4i+3:4i]`, `b_r[4i+3:4i]` and `c_r`.
  - On the edge, the sum nibble is written into the partial register and `c_r` takes the adder cout.
  - `idx` increments.
- Final RUN edge: load `result` = {last sum nibble, partial[WIDTH−5:0]}, `cout` = adder cout, and `overflow` = (`a_r` MSB == `b_r` MSB) & (result MSB != `a_r` MSB).
- Output stability: `result`, `cout` and `overflow` hold between operations. They change only on a final RUN edge or on reset. Partial results are never visible on `result`.
- `start` while in RUN is ignored; no queuing. Operands changing during RUN have no effect.
- Exactly one adder instance exists; no other arithmetic on the nibble path.

## Timing
- Reset (async, any state, including mid-RUN): state=IDLE, `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0. Internal registers and `idx` are cleared. The aborted operation produces no `done`.
- Accepting edge E0: `busy`=1 from E0.
- Nibble i is registered at edge E(i+1).
- `done`=1 and `busy`=0 for the single cycle after edge E(N). For WIDTH=16, `done` is high 4 cycles after the accepting edge.
- Back-to-back throughput: `start` held high in the DONE cycle is accepted. The next `done` follows N+1 edges after the previous `done`; one operation per N+1 cycles.
- `busy` and `done` are never high simultaneously.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the nibble width constant 4;
  - a function returning WIDTH/4.
- Sub-module: one `carry_lookahead_adder` instance (4-bit, cin/cout), instantiated unchanged.
- Everything else lives in this module: FSM, operand/carry/index registers, output registers.

## Test plan
- Add: `a`=0x1234, `b`=0x0FFF, `op_sub`=0 → `result`=0x2233, `cout`=0, `overflow`=0. `done` lands exactly 4 cycles after acceptance; `busy` is high for 4 cycles.
- Subtract with borrow: `a`=0x0005, `b`=0x0007, `op_sub`=1 → `result`=0xFFFE, `cout`=0, `overflow`=0.
- Signed overflow: `a`=0x7FFF + `b`=0x0001 → 0x8000, `overflow`=1, `cout`=0. Then `a`=0xFFFF + `b`=0x0001 → 0x0000, `cout`=1, `overflow`=0. The second operation is issued with `start` high during the first `done` cycle.
- Ignored start: a second `start` with different operands 2 cycles into RUN → first result unchanged, a single `done`, FSM returns to IDLE.
- Reset mid-op: assert `rst` asynchronously during RUN cycle 2 → all outputs are 0 immediately, no `done`. A fresh `start` (0x8000−0x0001) → `result`=0x7FFF, `cout`=1, `overflow`=1.
